// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master: FSM states,
// default timing parameters and the clock-polarity setting.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CLK_DIV    = 4;
   localparam int DEF_CS_SETUP   = 4;
   localparam int DEF_CS_HOLD    = 4;

   localparam logic [1:0] SPI_MODE = 2'd0;
   localparam logic       SPI_CPOL = SPI_MODE[1];

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer bringing the asynchronous MISO line into the clk domain.
module spi_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;

   // two-stage resynchronization register chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: shifts tx_data out MSB first on MOSI, samples MISO on
// each SCLK fall and returns the received word with a one-cycle done pulse.
module spi_master_tx
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int CS_SETUP   = DEF_CS_SETUP,
   parameter int CS_HOLD    = DEF_CS_HOLD
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  sclk,
   output logic                  cs,
   output logic                  mosi,
   input  logic                  miso
);

   localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD));
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

   state_t                state_r, state_s;
   logic [CNT_W-1:0]      cnt_r, cnt_s;
   logic [BIT_W-1:0]      bit_r, bit_s;
   logic [DATA_WIDTH-1:0] tx_sh_r, tx_sh_s;
   logic [DATA_WIDTH-1:0] rx_sh_r, rx_sh_s;
   logic [DATA_WIDTH-1:0] rx_data_r, rx_data_s;
   logic                  sclk_r, sclk_s;
   logic                  cs_r, cs_s;
   logic                  mosi_r, mosi_s;
   logic                  busy_r, busy_s;
   logic                  done_r, done_s;
   logic                  miso_s;

   spi_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (miso),
      .q     (miso_s)
   );

   // next-state and next-output decode for the transfer sequencer
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      bit_s     = bit_r;
      tx_sh_s   = tx_sh_r;
      rx_sh_s   = rx_sh_r;
      rx_data_s = rx_data_r;
      sclk_s    = sclk_r;
      cs_s      = cs_r;
      mosi_s    = mosi_r;
      busy_s    = busy_r;
      done_s    = 1'b0;

      case (state_r)
         IDLE: begin
            if (start) begin
               tx_sh_s = tx_data;
               rx_sh_s = '0;
               cnt_s   = '0;
               bit_s   = '0;
               state_s = SETUP;
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: begin
            // cs still high marks the first SETUP cycle: assert cs and present the MSB
            if (cs_r) begin
               cs_s   = 1'b0;
               busy_s = 1'b1;
               mosi_s = tx_sh_r[DATA_WIDTH-1];
               cnt_s  = '0;
            end else if (cnt_r == SETUP_LAST) begin
               sclk_s  = 1'b1;
               cnt_s   = '0;
               state_s = XFER;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         XFER: begin
            if (cnt_r == DIV_LAST) begin
               cnt_s = '0;
               if (!sclk_r) begin
                  sclk_s = 1'b1;
               end else begin
                  // falling edge: capture MISO first, then advance MOSI
                  sclk_s  = 1'b0;
                  rx_sh_s = {rx_sh_r[DATA_WIDTH-2:0], miso_s};
                  if (bit_r == BIT_LAST) begin
                     mosi_s  = 1'b0;
                     bit_s   = '0;
                     state_s = HOLD;
                  end else begin
                     tx_sh_s = {tx_sh_r[DATA_WIDTH-2:0], 1'b0};
                     mosi_s  = tx_sh_r[DATA_WIDTH-2];
                     bit_s   = bit_r + BIT_W'(1);
                  end
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         HOLD: begin
            if (cnt_r == HOLD_LAST) begin
               cs_s      = 1'b1;
               busy_s    = 1'b0;
               done_s    = 1'b1;
               rx_data_s = rx_sh_r;
               cnt_s     = '0;
               // a request in the done cycle chains straight into the next frame
               if (start) begin
                  tx_sh_s = tx_data;
                  rx_sh_s = '0;
                  bit_s   = '0;
                  state_s = SETUP;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
            bit_s   = '0;
            sclk_s  = SPI_CPOL;
            cs_s    = 1'b1;
            mosi_s  = 1'b0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // state, counters, shifters and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         bit_r     <= '0;
         tx_sh_r   <= '0;
         rx_sh_r   <= '0;
         rx_data_r <= '0;
         sclk_r    <= SPI_CPOL;
         cs_r      <= 1'b1;
         mosi_r    <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         bit_r     <= bit_s;
         tx_sh_r   <= tx_sh_s;
         rx_sh_r   <= rx_sh_s;
         rx_data_r <= rx_data_s;
         sclk_r    <= sclk_s;
         cs_r      <= cs_s;
         mosi_r    <= mosi_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign rx_data = rx_data_r;
   assign sclk    = sclk_r;
   assign cs      = cs_r;
   assign mosi    = mosi_r;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx with default parameters; every expected
// value is derived from the frame timeline counted from the acceptance edge.
module tb_spi_master_tx;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] tx_data;
   logic       busy;
   logic       done;
   logic [7:0] rx_data;
   logic       sclk;
   logic       cs;
   logic       mosi;
   logic       miso;
   logic       loop_en;
   logic       miso_lvl;

   int checks   = 0;
   int failures = 0;
   int rises    = 0;

   spi_master_tx dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .tx_data (tx_data),
      .busy    (busy),
      .done    (done),
      .rx_data (rx_data),
      .sclk    (sclk),
      .cs      (cs),
      .mosi    (mosi),
      .miso    (miso)
   );

   assign miso = loop_en ? mosi : miso_lvl;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge sclk) rises++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // raise start with word d; returns just after the acceptance edge E0
   task automatic begin_frame(input logic [7:0] d);
      start   = 1'b1;
      tx_data = d;
      @(posedge clk);
      #1;
      start   = 1'b0;
      tx_data = ~d;
      chk("e0_busy", {31'd0, busy}, 32'd0);
   endtask

   // called just after E0; checks every cycle E1..E69 against the timeline
   task automatic frame(input logic [7:0] d, input logic [7:0] prev_rx,
                        input logic [7:0] exp_rx, input bit intrude);
      logic s_exp;
      logic m_exp;
      rises = 0;
      for (int e = 1; e <= 69; e++) begin
         @(posedge clk);
         #1;
         s_exp = (e >= 5) && (e <= 64) && (((e - 5) % 8) < 4);
         m_exp = (e <= 64) ? d[7 - ((e - 1) / 8)] : 1'b0;
         chk($sformatf("sclk_e%0d", e), {31'd0, sclk}, {31'd0, s_exp});
         chk($sformatf("cs_e%0d", e),   {31'd0, cs},   (e == 69) ? 32'd1 : 32'd0);
         chk($sformatf("busy_e%0d", e), {31'd0, busy}, (e == 69) ? 32'd0 : 32'd1);
         chk($sformatf("done_e%0d", e), {31'd0, done}, (e == 69) ? 32'd1 : 32'd0);
         chk($sformatf("mosi_e%0d", e), {31'd0, mosi}, {31'd0, m_exp});
         chk($sformatf("rx_e%0d", e),   {24'd0, rx_data},
             (e == 69) ? {24'd0, exp_rx} : {24'd0, prev_rx});
         if (intrude && e == 19) begin
            start   = 1'b1;
            tx_data = 8'hFF;
         end
         if (intrude && e == 20) begin
            start = 1'b0;
         end
      end
      chk("rise_count", rises, 32'd8);
   endtask

   task automatic idle_check(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         chk({tag, "_cs"},   {31'd0, cs},   32'd1);
         chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
         chk({tag, "_done"}, {31'd0, done}, 32'd0);
         chk({tag, "_sclk"}, {31'd0, sclk}, 32'd0);
      end
   endtask

   initial begin
      rst_n    = 1'b1;
      start    = 1'b1;
      tx_data  = 8'hA5;
      loop_en  = 1'b0;
      miso_lvl = 1'b0;

      // 1: reset asserted between clock edges, start held high throughout
      #3 rst_n = 1'b0;
      #1;
      chk("rst_cs",   {31'd0, cs},   32'd1);
      chk("rst_sclk", {31'd0, sclk}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_mosi", {31'd0, mosi}, 32'd0);
      chk("rst_rx",   {24'd0, rx_data}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_cs",   {31'd0, cs},   32'd1);
      chk("rst_hold_busy", {31'd0, busy}, 32'd0);
      start = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle_check("post_rst", 3);

      // 2: 0xA5 with miso low
      begin_frame(8'hA5);
      frame(8'hA5, 8'h00, 8'h00, 1'b0);

      // 3: loopback 0x3C, then miso tied high
      loop_en = 1'b1;
      begin_frame(8'h3C);
      frame(8'h3C, 8'h00, 8'h3C, 1'b0);
      loop_en  = 1'b0;
      miso_lvl = 1'b1;
      begin_frame(8'h00);
      frame(8'h00, 8'h3C, 8'hFF, 1'b0);

      // 4: start with 0xFF at E20 during a frame is ignored
      miso_lvl = 1'b0;
      begin_frame(8'h5A);
      frame(8'h5A, 8'hFF, 8'h00, 1'b1);
      idle_check("no_requeue", 10);

      // 5: start held high, second word taken in the done cycle
      loop_en = 1'b1;
      start   = 1'b1;
      tx_data = 8'h81;
      @(posedge clk);
      #1;
      tx_data = 8'h7E;
      frame(8'h81, 8'h00, 8'h81, 1'b0);
      start = 1'b0;
      frame(8'h7E, 8'h81, 8'h7E, 1'b0);
      idle_check("b2b_end", 4);

      // 6: reset pulse at E30 aborts, next frame runs normally
      begin_frame(8'hC3);
      repeat (29) @(posedge clk);
      #1;
      chk("pre_abort_sclk", {31'd0, sclk}, 32'd1);
      chk("pre_abort_cs",   {31'd0, cs},   32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_sclk", {31'd0, sclk}, 32'd0);
      chk("abort_cs",   {31'd0, cs},   32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_mosi", {31'd0, mosi}, 32'd0);
      chk("abort_rx",   {24'd0, rx_data}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle_check("post_abort", 60);
      chk("post_abort_rx", {24'd0, rx_data}, 32'd0);
      begin_frame(8'h55);
      frame(8'h55, 8'h00, 8'h55, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI mode-0 master that drives SCLK, CS and MOSI toward the SPI peripheral and samples MISO on the return path.
- It is the transmit end of the link whose receive side is conditioned by the input conditioner.
- The SCLK half-period is a parameter, so edges are slow enough to pass the peripheral's synchronizer and debounce stages.
- Sits between a host-side request interface (start/data/done) and the package pins.

Parameters:
DATA_WIDTH, 8, bits per transfer, MSB first; legal 2..32
CLK_DIV, 4, clk cycles per SCLK half-period; legal >= 3
CS_SETUP, 4, clk cycles from CS falling to first SCLK rise; legal >= 1
CS_HOLD, 4, clk cycles from last SCLK fall to CS rising; legal >= 1

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  request; accepted only in a cycle where busy=0
tx_data  in  DATA_WIDTH  word to send, latched when start is accepted
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle pulse at end of transfer
rx_data  out  DATA_WIDTH  word received; updated in the done cycle, held otherwise
sclk  out  1  SPI clock, idle low
cs  out  1  chip select, active low, idle high
mosi  out  1  serial data out
miso  in  1  serial data in, asynchronous to clk

Behaviour:
- Reset (async assert, sync deassert) forces outputs immediately:
  - busy=0, done=0, rx_data=0, sclk=0, cs=1, mosi=0.
  - State=IDLE, all counters cleared.
- Reset mid-transfer aborts it: no done pulse, rx_data keeps its reset value of 0.
- All outputs are registered.
- States:
  - IDLE -> SETUP: on start at edge E0, tx_data is latched. At E1: cs=0, busy=1, mosi=tx_data[MSB].
  - SETUP -> XFER: after CS_SETUP cycles, sclk rises.
  - XFER: sclk toggles every CLK_DIV cycles.
    - Rise (high phase begins): no data change.
    - Fall: shift, mosi <= next bit. miso is sampled in the fall cycle, from a 2-flop synchronized copy, before the shift.
    - The DATA_WIDTH-th fall leaves sclk=0, sets mosi=0 and moves to HOLD.
  - HOLD -> IDLE: after CS_HOLD cycles: cs=1, busy=0, done=1 for one cycle, rx_data updated.
- Total transfer from the E0 acceptance edge to the done edge: 1 + CS_SETUP + (2*DATA_WIDTH-1)*CLK_DIV + CS_HOLD cycles.
  - With defaults: cs falls at E1, first rise at E5, rises at E5+8k, falls at E9+8k (k=0..7), done/cs high at E69.
- Exactly DATA_WIDTH rising sclk edges per transfer; no glitch or partial pulse on sclk or cs.
- Start handling:
  - start while busy=1: ignored, no queuing.
  - start in the done cycle (busy=0) is accepted. cs is then high for exactly one cycle between transfers.
- tx_data changes after acceptance have no effect.
- rx_data bit order: first sampled bit lands in rx_data[MSB].
- Bit counter width is $clog2(DATA_WIDTH+1). Half-period counter width is $clog2(max(CLK_DIV, CS_SETUP, CS_HOLD)).
- No arithmetic wrap is permitted within a transfer.

Decomposition:
- spi_pkg:
  - State enum (IDLE, SETUP, XFER, HOLD).
  - Default parameter constants.
  - SPI mode constant (mode 0).
- One sub-module, spi_sync2: 2-flop synchronizer for miso. It is reset asynchronously to 0 and produces the sampled MISO value. Its 2-cycle delay is covered by CLK_DIV >= 3.

Test Plan:
1. Reset check: assert rst_n=0 mid-clock -> outputs go to idle values immediately without waiting for a clk edge; hold start=1 during reset -> no transfer starts.
2. Send 0xA5, miso=0:
   - start at E0 -> cs=0 at E1.
   - mosi at each sclk rise = 1,0,1,0,0,1,0,1.
   - Rises at E5,E13,…,E61; 8 rises total.
   - cs=1, done=1 (single cycle), busy=0 at E69; rx_data=0x00.
3. Loopback (miso=mosi) with 0x3C -> rx_data=0x3C at done. With miso tied 1 -> rx_data=0xFF.
4. start pulsed at E20 during a transfer with tx_data=0xFF -> ignored; frame still carries the original word; single done.
5. Back-to-back: start held high continuously with 0x81 then 0x7E:
   - Second accepted in the done cycle E69.
   - cs high only at E69, low again at E70.
   - Second frame's mosi = 0x7E.
6. Reset pulse at E30 mid-transfer -> sclk=0, cs=1, busy=0 immediately, no done. Then start 0x55 -> full normal frame, rx_data correct.
